axis_addr_resp: RTL and testbench
=================================

// Module: axis_addr_resp
// PURPOSE
//  Responder end of the AXI address channel: accepts axi_aid/aaddr/alen/avalid
//  bursts, queues them in a small command FIFO, expands each into one beat per
//  data word (id, byte address, last flag) on a valid/ready beat stream.
//  Sits in front of the memory-side data mover or on-chip memory model.
// PARAMETERS
//  AXI_ID_WIDTH    8    width of burst id
//  AXI_LEN_WIDTH   8    width of alen (beats-1)
//  AXI_ADDR_WIDTH  32   byte address width
//  AXI_DATA_WIDTH  256  data word width; beat stride = AXI_DATA_WIDTH/8 bytes
//  CMD_DEPTH_LOG2  2    command FIFO depth = 2**CMD_DEPTH_LOG2 (>=1)
// PORTS
//  clk         in   1                 clock
//  rst         in   1                 synchronous reset, active-high
//  axi_aready  out  1                 FIFO can take a command
//  axi_aid     in   AXI_ID_WIDTH      burst id
//  axi_aaddr   in   AXI_ADDR_WIDTH    start byte address
//  axi_alen    in   AXI_LEN_WIDTH     beats in burst minus 1
//  axi_avalid  in   1                 command valid
//  beat_id     out  AXI_ID_WIDTH      id of current burst
//  beat_addr   out  AXI_ADDR_WIDTH    byte address of current beat
//  beat_last   out  1                 final beat of burst
//  beat_valid  out  1                 beat presented
//  beat_ready  in   1                 downstream takes beat
//  cmd_level   out  CMD_DEPTH_LOG2+1  commands held in FIFO (excl. active burst)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: FIFO empty, cmd_level=0,
//    beat_valid=0, beat_last=0, beat_id=0, beat_addr=0, state IDLE; any burst
//    in progress or queued is dropped. axi_aready=0 while rst high.
//  - axi_aready = ~rst & ~full (combinational). Push on axi_avalid&axi_aready.
//    Push and pop in the same cycle leave cmd_level unchanged; push while
//    full cannot occur.
//  - States (one-hot): IDLE, BURST.
//    IDLE: beat_valid=0. If FIFO non-empty: pop head, load id/addr/len,
//     beat counter=0, -> BURST (first beat_valid the cycle after pop;
//     command-to-first-beat latency 2 cycles from accept into empty FIFO).
//    BURST: beat_valid=1; beat_last=(beat_cnt==len). On beat_valid&beat_ready:
//     not last -> beat_addr += AXI_DATA_WIDTH/8, beat_cnt+=1;
//     last & FIFO non-empty -> pop and load next command, stay BURST
//     (back-to-back bursts, no bubble); last & FIFO empty -> IDLE.
//  - beat_* stable while beat_valid & ~beat_ready.
//  - Address arithmetic modulo 2**AXI_ADDR_WIDTH (wraps silently at top);
//    start address passed unchanged, no alignment correction.
//  - alen=0: single beat with beat_last=1 on first beat.
//  - alen=all-ones: 2**AXI_LEN_WIDTH beats; beat_cnt is AXI_LEN_WIDTH wide,
//    compared with len, never overflows.
//  - Beat order equals command accept order; id passed through untouched.
// TESTING
//  1 Single cmd id=3 addr=0x1000 len=3, beat_ready=1 -> 4 beats addrs
//    0x1000,0x1020,0x1040,0x1060 id=3, beat_last only on 4th, first beat
//    2 cycles after accept.
//  2 Push 5 cmds with beat_ready=0 (depth 4) -> 1 active, 4 queued,
//    cmd_level=4, axi_aready=0; release ready -> all beats in order, no gap
//    between bursts.
//  3 len=0 cmds back-to-back -> one beat each, beat_last=1 every beat,
//    beat_valid continuous.
//  4 addr=0xFFFFFFC0 len=3 -> addrs 0xFFFFFFC0,0xFFFFFFE0,0x00000000,
//    0x00000020.
//  5 Random beat_ready stalls -> beat_* held stable during stall,
//    beat count per burst = len+1.
//  6 rst asserted mid-burst with 2 cmds queued -> next cycle beat_valid=0,
//    cmd_level=0, axi_aready=1 after release; new cmd served normally.

Source files
------------

// File: rtl/axis_addr_resp_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_addr_resp_if
// Purpose  : AXI address channel plus expanded beat stream for axis_addr_resp
// Revision : 1.0 - initial release
// ============================================================================
interface axis_addr_resp_if #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                      axi_aready;
    logic [AXI_ID_WIDTH-1:0]   axi_aid;
    logic [AXI_ADDR_WIDTH-1:0] axi_aaddr;
    logic [AXI_LEN_WIDTH-1:0]  axi_alen;
    logic                      axi_avalid;
    logic [AXI_ID_WIDTH-1:0]   beat_id;
    logic [AXI_ADDR_WIDTH-1:0] beat_addr;
    logic                      beat_last;
    logic                      beat_valid;
    logic                      beat_ready;

    // Responder view: takes commands, produces beats.
    modport slave (
        output axi_aready,
        input  axi_aid, axi_aaddr, axi_alen, axi_avalid,
        output beat_id, beat_addr, beat_last, beat_valid,
        input  beat_ready
    );

    modport master (
        input  axi_aready,
        output axi_aid, axi_aaddr, axi_alen, axi_avalid,
        input  beat_id, beat_addr, beat_last, beat_valid,
        output beat_ready
    );
endinterface
`default_nettype wire

// File: rtl/axis_addr_resp.sv
`default_nettype none
// ============================================================================
// Module   : axis_addr_resp
// Purpose  : Queues AXI address bursts and expands each into per-beat id/addr/last
// Revision : 1.0 - initial release
// ============================================================================
module axis_addr_resp #(
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int CMD_DEPTH_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    axis_addr_resp_if.slave         s,
    output logic [CMD_DEPTH_LOG2:0] cmd_level
);
    localparam int DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        BURST = 2'b10
    } state_t;

    logic [AXI_ID_WIDTH-1:0]   fifo_id   [DEPTH];
    logic [AXI_ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [AXI_LEN_WIDTH-1:0]  fifo_len  [DEPTH];
    logic [CMD_DEPTH_LOG2-1:0] wr_ptr;
    logic [CMD_DEPTH_LOG2-1:0] rd_ptr;
    logic [CMD_DEPTH_LOG2:0]   count;

    state_t                    state;
    logic [AXI_ID_WIDTH-1:0]   cur_id;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [AXI_LEN_WIDTH-1:0]  cur_len;
    logic [AXI_LEN_WIDTH-1:0]  beat_cnt;
    logic                      cur_last;
    logic                      cur_valid;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic burst_done;

    assign full       = (count == (CMD_DEPTH_LOG2 + 1)'(DEPTH));
    assign empty      = (count == '0);
    assign s.axi_aready = ~rst & ~full;
    assign push       = s.axi_avalid & s.axi_aready;
    assign burst_done = (state == BURST) & cur_valid & s.beat_ready & cur_last;
    // The head is consumed either to start from idle or to chain straight after a last beat.
    assign pop        = ~empty & ((state == IDLE) | burst_done);

    assign s.beat_id    = cur_id;
    assign s.beat_addr  = cur_addr;
    assign s.beat_last  = cur_last;
    assign s.beat_valid = cur_valid;
    assign cmd_level    = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]   <= s.axi_aid;
            fifo_addr[wr_ptr] <= s.axi_aaddr;
            fifo_len[wr_ptr]  <= s.axi_alen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_id    <= '0;
            cur_addr  <= '0;
            cur_len   <= '0;
            beat_cnt  <= '0;
            cur_last  <= 1'b0;
            cur_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_id    <= fifo_id[rd_ptr];
                        cur_addr  <= fifo_addr[rd_ptr];
                        cur_len   <= fifo_len[rd_ptr];
                        beat_cnt  <= '0;
                        cur_last  <= (fifo_len[rd_ptr] == '0);
                        cur_valid <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (s.beat_ready) begin
                        if (!cur_last) begin
                            cur_addr <= cur_addr + STRIDE;
                            beat_cnt <= beat_cnt + 1'b1;
                            // Last flag is precomputed so it is registered alongside the address.
                            cur_last <= ((beat_cnt + AXI_LEN_WIDTH'(1)) == cur_len);
                        end else if (!empty) begin
                            cur_id   <= fifo_id[rd_ptr];
                            cur_addr <= fifo_addr[rd_ptr];
                            cur_len  <= fifo_len[rd_ptr];
                            beat_cnt <= '0;
                            cur_last <= (fifo_len[rd_ptr] == '0);
                        end else begin
                            cur_valid <= 1'b0;
                            cur_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    cur_valid <= 1'b0;
                    cur_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axis_addr_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_addr_resp
// Purpose  : Directed self-checking bench for axis_addr_resp
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_addr_resp;
    logic       clk;
    logic       rst;
    logic [2:0] cmd_level;
    int         checks;
    int         errors;
    int         idx;
    int         n;

    axis_addr_resp_if #(.AXI_ID_WIDTH(8), .AXI_LEN_WIDTH(8), .AXI_ADDR_WIDTH(32)) bus ();

    axis_addr_resp #(
        .AXI_ID_WIDTH(8), .AXI_LEN_WIDTH(8), .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(256), .CMD_DEPTH_LOG2(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(bus),
        .cmd_level(cmd_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] id, input logic [31:0] addr,
                        input logic last);
        chk({tag, "_valid"}, 64'(bus.beat_valid), 64'd1);
        chk({tag, "_id"},    64'(bus.beat_id),    64'(id));
        chk({tag, "_addr"},  64'(bus.beat_addr),  64'(addr));
        chk({tag, "_last"},  64'(bus.beat_last),  64'(last));
    endtask

    // Presents a command for one edge; caller decides when to drop avalid.
    task automatic send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        bus.axi_aid    = id;
        bus.axi_aaddr  = addr;
        bus.axi_alen   = len;
        bus.axi_avalid = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.axi_avalid = 1'b0;
        bus.axi_aid    = '0;
        bus.axi_aaddr  = '0;
        bus.axi_alen   = '0;
        bus.beat_ready = 1'b0;

        repeat (3) step();
        chk("rst_valid",  64'(bus.beat_valid), 64'd0);
        chk("rst_last",   64'(bus.beat_last),  64'd0);
        chk("rst_id",     64'(bus.beat_id),    64'd0);
        chk("rst_addr",   64'(bus.beat_addr),  64'd0);
        chk("rst_level",  64'(cmd_level),      64'd0);
        chk("rst_aready", 64'(bus.axi_aready), 64'd0);
        rst = 1'b0;
        #1;
        chk("aready_after_rst", 64'(bus.axi_aready), 64'd1);

        // Single 4-beat burst with two-cycle first-beat latency.
        bus.beat_ready = 1'b1;
        send(8'd3, 32'h1000, 8'd3);
        bus.axi_avalid = 1'b0;
        chk("t1_lat_valid", 64'(bus.beat_valid), 64'd0);
        chk("t1_lat_level", 64'(cmd_level),      64'd1);
        step(); beat("t1_b0", 8'd3, 32'h1000, 1'b0);
        step(); beat("t1_b1", 8'd3, 32'h1020, 1'b0);
        step(); beat("t1_b2", 8'd3, 32'h1040, 1'b0);
        step(); beat("t1_b3", 8'd3, 32'h1060, 1'b1);
        step(); chk("t1_end_valid", 64'(bus.beat_valid), 64'd0);

        // Fill: one active plus four queued, then drain without bubbles.
        bus.beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_aready_fill", 64'(bus.axi_aready), 64'd1);
            send(8'(10 + i), 32'(32'h2000 + i * 32'h100), 8'd1);
        end
        bus.axi_avalid = 1'b0;
        chk("t2_level_full",  64'(cmd_level),      64'd4);
        chk("t2_aready_full", 64'(bus.axi_aready), 64'd0);
        beat("t2_hold0", 8'd10, 32'h2000, 1'b0);
        step(); beat("t2_hold1", 8'd10, 32'h2000, 1'b0);
        step(); beat("t2_hold2", 8'd10, 32'h2000, 1'b0);
        bus.beat_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 2; b++) begin
                beat("t2_drain", 8'(10 + i), 32'(32'h2000 + i * 32'h100 + b * 32'h20), b == 1);
                step();
            end
        end
        chk("t2_end_valid", 64'(bus.beat_valid), 64'd0);
        chk("t2_end_level", 64'(cmd_level),      64'd0);

        // Back-to-back single-beat bursts.
        for (int i = 0; i < 3; i++) begin
            send(8'(20 + i), 32'(32'h3000 + i * 32'h100), 8'd0);
            if (i > 0) beat("t3_b", 8'(20 + i - 1), 32'(32'h3000 + (i - 1) * 32'h100), 1'b1);
        end
        bus.axi_avalid = 1'b0;
        step(); beat("t3_b2", 8'd22, 32'h3200, 1'b1);
        step(); chk("t3_end_valid", 64'(bus.beat_valid), 64'd0);

        // Address wrap at the top of the space.
        send(8'd5, 32'hFFFF_FFC0, 8'd3);
        bus.axi_avalid = 1'b0;
        step(); beat("t4_b0", 8'd5, 32'hFFFF_FFC0, 1'b0);
        step(); beat("t4_b1", 8'd5, 32'hFFFF_FFE0, 1'b0);
        step(); beat("t4_b2", 8'd5, 32'h0000_0000, 1'b0);
        step(); beat("t4_b3", 8'd5, 32'h0000_0020, 1'b1);
        step(); chk("t4_end_valid", 64'(bus.beat_valid), 64'd0);

        // Random stalls: a stalled beat must match the same expected index.
        bus.beat_ready = 1'b0;
        send(8'd7, 32'h4000, 8'd5);
        bus.axi_avalid = 1'b0;
        idx = 0;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            step();
            if (bus.beat_valid) begin
                chk("t5_addr", 64'(bus.beat_addr), 64'(32'h4000 + idx * 32'h20));
                chk("t5_last", 64'(bus.beat_last), 64'(idx == 5));
                chk("t5_id",   64'(bus.beat_id),   64'd7);
                bus.beat_ready = 1'($urandom_range(0, 1));
                if (bus.beat_ready) idx++;
            end
        end
        chk("t5_count", 64'(idx), 64'd6);
        step(); chk("t5_end_valid", 64'(bus.beat_valid), 64'd0);
        bus.beat_ready = 1'b1;

        // Maximum length burst: 256 beats.
        send(8'd9, 32'h0, 8'hFF);
        bus.axi_avalid = 1'b0;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (bus.beat_valid) begin
                chk("t7_addr", 64'(bus.beat_addr), 64'(32'(n * 32)));
                chk("t7_last", 64'(bus.beat_last), 64'(n == 255));
                n++;
            end else if (n > 0) begin
                break;
            end
        end
        chk("t7_count", 64'(n), 64'd256);

        // Reset mid-burst with two commands queued.
        bus.beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(30 + i), 32'(32'h6000 + i * 32'h100), 8'd3);
        bus.axi_avalid = 1'b0;
        chk("t6_level_pre", 64'(cmd_level),      64'd2);
        chk("t6_valid_pre", 64'(bus.beat_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("t6_rst_valid",  64'(bus.beat_valid), 64'd0);
        chk("t6_rst_level",  64'(cmd_level),      64'd0);
        chk("t6_rst_aready", 64'(bus.axi_aready), 64'd0);
        rst = 1'b0;
        #1;
        chk("t6_aready_rel", 64'(bus.axi_aready), 64'd1);
        bus.beat_ready = 1'b1;
        send(8'd40, 32'h5000, 8'd0);
        bus.axi_avalid = 1'b0;
        chk("t6_lat_valid", 64'(bus.beat_valid), 64'd0);
        step(); beat("t6_new", 8'd40, 32'h5000, 1'b1);
        step(); chk("t6_end_valid", 64'(bus.beat_valid), 64'd0);
        chk("t6_end_level", 64'(cmd_level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
